uart_image_ctrl: RTL and testbench

UART_IMAGE_CTRL -- requirements
Module: uart_image_ctrl

---
 rtl/uart_image_ctrl_pkg.sv | 17 +
 rtl/uart_image_ctrl_if.sv | 25 ++
 rtl/uart_image_dumper.sv | 82 ++++++++
 rtl/uart_image_ctrl.sv | 137 +++++++++++++
 tb/tb_uart_image_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_image_ctrl_pkg.sv
// Shared types for the UART image controller.
// State encoding as seen on state_o, plus default bus widths.
package uart_image_ctrl_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    S_LOAD      = 3'd0,
    S_HOST      = 3'd1,
    S_DUMP_RD   = 3'd2,
    S_DUMP_LAT  = 3'd3,
    S_DUMP_TX   = 3'd4,
    S_DUMP_WAIT = 3'd5
  } state_e;

endpackage

// File: rtl/uart_image_ctrl_if.sv
// RAM port bundle between the image controller and an external RAM.
// master: drives ram_addr/ram_wdata/ram_we, reads ram_rdata (1-cycle read).
interface uart_image_ctrl_if
  import uart_image_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata
  );

endinterface

// File: rtl/uart_image_dumper.sv
// Dump sequencer: read RAM byte, wait latency, hand to UART TX, wait done.
// Ports: start_i/abort_i control, base_i/len_i, rdata_i, tx_*, state_o, fin_o.
module uart_image_dumper
  import uart_image_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              tx_done_i,
  output logic              tx_start_o,
  output logic [DATA_W-1:0] tx_byte_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output state_e            state_o,
  output logic              fin_o
);

  state_e            state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W:0]   rd_rem_q;
  logic [DATA_W-1:0] tx_byte_q;
  logic              tx_start_q;
  logic              last;

  assign last = rd_rem_q == (ADDR_W+1)'(1);

  assign fin_o = (state_q == S_DUMP_WAIT) && tx_done_i
              && last && !abort_i;

  assign tx_start_o = tx_start_q;
  assign tx_byte_o  = tx_byte_q;
  assign rd_addr_o  = rd_addr_q;
  assign state_o    = state_q;

  // S_HOST doubles as the idle state of this sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HOST;
      rd_addr_q  <= '0;
      rd_rem_q   <= '0;
      tx_byte_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      if (abort_i) begin
        state_q <= S_HOST;
      end else begin
        unique case (state_q)
          S_HOST: begin
            if (start_i) begin
              rd_addr_q <= base_i;
              rd_rem_q  <= len_i;
              if (len_i != '0) state_q <= S_DUMP_RD;
            end
          end
          S_DUMP_RD:  state_q <= S_DUMP_LAT;
          S_DUMP_LAT: state_q <= S_DUMP_TX;
          S_DUMP_TX: begin
            tx_byte_q  <= rdata_i;
            tx_start_q <= 1'b1;
            state_q    <= S_DUMP_WAIT;
          end
          S_DUMP_WAIT: begin
            if (tx_done_i) begin
              rd_addr_q <= rd_addr_q + 1'b1;
              rd_rem_q  <= rd_rem_q - 1'b1;
              state_q   <= last ? S_HOST : S_DUMP_RD;
            end
          end
          default: state_q <= S_HOST;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_image_ctrl.sv
// UART image controller: load image bytes to RAM, host access, dump results.
// Ports: clk/rst_n, rx_*, tx_*, ram bus (master), ext_*, control, status.
module uart_image_ctrl
  import uart_image_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int IMG_LEN = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_byte_i,
  output logic              tx_start_o,
  output logic [DATA_W-1:0] tx_byte_o,
  input  logic              tx_done_i,
  uart_image_ctrl_if.master ram,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  input  logic              ext_we_i,
  input  logic              load_restart_i,
  input  logic              dump_start_i,
  input  logic [ADDR_W-1:0] dump_base_i,
  input  logic [ADDR_W:0]   dump_len_i,
  output logic              load_done_o,
  output logic              dump_done_o,
  output logic              overrun_o,
  output logic [2:0]        state_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_LEN - 1);

  // state_q holds S_LOAD, S_HOST or S_DUMP_RD; the latter means the
  // dumper owns the sequence and reports the fine-grained phase.
  state_e            state_q;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic              load_done_q;
  logic              dump_done_q;
  logic              overrun_q;
  logic              dump_go;
  logic              dump_fin;
  logic              dumping;
  logic [ADDR_W-1:0] rd_addr;
  state_e            dstate;

  assign dumping = state_q == S_DUMP_RD;
  assign dump_go = (state_q == S_HOST) && dump_start_i
                && !load_restart_i;

  uart_image_dumper #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dumper (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (dump_go),
    .abort_i    (load_restart_i),
    .base_i     (dump_base_i),
    .len_i      (dump_len_i),
    .rdata_i    (ram.ram_rdata),
    .tx_done_i  (tx_done_i),
    .tx_start_o (tx_start_o),
    .tx_byte_o  (tx_byte_o),
    .rd_addr_o  (rd_addr),
    .state_o    (dstate),
    .fin_o      (dump_fin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      wr_cnt_q    <= '0;
      load_done_q <= 1'b0;
      dump_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (load_restart_i) begin
      state_q     <= S_LOAD;
      wr_cnt_q    <= '0;
      load_done_q <= 1'b0;
      dump_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (rx_valid_i && state_q != S_LOAD) overrun_q <= 1'b1;
      unique case (state_q)
        S_LOAD: begin
          if (rx_valid_i) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST) begin
              load_done_q <= 1'b1;
              state_q     <= S_HOST;
            end
          end
        end
        S_HOST: begin
          if (dump_go) begin
            dump_done_q <= dump_len_i == '0;
            if (dump_len_i != '0) state_q <= S_DUMP_RD;
          end
        end
        default: begin
          if (dump_fin) begin
            dump_done_q <= 1'b1;
            state_q     <= S_HOST;
          end
        end
      endcase
    end
  end

  // RAM port mux; forced to zero while reset is held.
  always_comb begin
    ram.ram_addr  = '0;
    ram.ram_wdata = '0;
    ram.ram_we    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_LOAD: begin
          ram.ram_addr  = wr_cnt_q;
          ram.ram_wdata = rx_byte_i;
          ram.ram_we    = rx_valid_i;
        end
        S_HOST: begin
          ram.ram_addr  = ext_addr_i;
          ram.ram_wdata = ext_wdata_i;
          ram.ram_we    = ext_we_i;
        end
        default: ram.ram_addr = rd_addr;
      endcase
    end
  end

  assign load_done_o = load_done_q;
  assign dump_done_o = dump_done_q;
  assign overrun_o   = overrun_q;
  assign state_o     = dumping ? dstate : state_q;

endmodule

// File: tb/tb_uart_image_ctrl.sv
// Randomized bench for uart_image_ctrl against a byte-level memory model.
// Small config: ADDR_W=4, DATA_W=8, IMG_LEN=4.
module tb_uart_image_ctrl;
  import uart_image_ctrl_pkg::*;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int IL  = 4;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          rx_valid = 0;
  logic [DW-1:0] rx_byte = 0;
  logic          tx_start;
  logic [DW-1:0] tx_byte;
  logic          tx_done = 0;
  logic [AW-1:0] ext_addr = 0;
  logic [DW-1:0] ext_wdata = 0;
  logic          ext_we = 0;
  logic          load_restart = 0;
  logic          dump_start = 0;
  logic [AW-1:0] dump_base = 0;
  logic [AW:0]   dump_len = 0;
  logic          load_done, dump_done, overrun;
  logic [2:0]    state;

  uart_image_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

  uart_image_ctrl #(.ADDR_W(AW), .DATA_W(DW), .IMG_LEN(IL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_valid_i     (rx_valid),
    .rx_byte_i      (rx_byte),
    .tx_start_o     (tx_start),
    .tx_byte_o      (tx_byte),
    .tx_done_i      (tx_done),
    .ram            (ram_if),
    .ext_addr_i     (ext_addr),
    .ext_wdata_i    (ext_wdata),
    .ext_we_i       (ext_we),
    .load_restart_i (load_restart),
    .dump_start_i   (dump_start),
    .dump_base_i    (dump_base),
    .dump_len_i     (dump_len),
    .load_done_o    (load_done),
    .dump_done_o    (dump_done),
    .overrun_o      (overrun),
    .state_o        (state)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (ram_if.ram_we) ram[ram_if.ram_addr] <= ram_if.ram_wdata;
    ram_if.ram_rdata <= ram[ram_if.ram_addr];
  end

  logic [DW-1:0] ref_mem [16];
  int            m_wr;
  bit            m_load, m_ovr, m_dd;
  int            total = 0;
  int            bad = 0;
  int            n_start = 0;
  logic [DW-1:0] txq [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // UART TX stand-in: logs each byte, answers tx_done ~10 cycles later.
  always begin : tx_resp
    logic [DW-1:0] b;
    @(negedge clk);
    if (tx_start === 1'b1) begin
      b = tx_byte;
      txq.push_back(b);
      n_start++;
      @(negedge clk);
      chk("tx_pulse", tx_start, 0);
      repeat (9) begin
        @(negedge clk);
        chk("tx_hold", tx_byte, b);
      end
      tx_done = 1;
      @(negedge clk);
      tx_done = 0;
    end
  end

  task automatic model_clear();
    m_wr = 0; m_load = 0; m_ovr = 0; m_dd = 0;
  endtask

  task automatic send(input logic [DW-1:0] b);
    @(negedge clk);
    rx_valid = 1; rx_byte = b;
    #1;
    chk("wr_we", ram_if.ram_we, 1);
    chk("wr_addr", ram_if.ram_addr, m_wr);
    chk("wr_data", ram_if.ram_wdata, b);
    ref_mem[m_wr] = b;
    if (m_wr == IL - 1) m_load = 1;
    m_wr++;
    @(negedge clk);
    rx_valid = 0;
    chk("ld_done", load_done, m_load);
    chk("ld_state", state, m_load ? S_HOST : S_LOAD);
    repeat ($urandom % 3) begin
      @(negedge clk);
      #1 chk("idle_we", ram_if.ram_we, 0);
    end
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ext_we = 1; ext_addr = a; ext_wdata = d;
    #1;
    chk("hw_we", ram_if.ram_we, 1);
    chk("hw_addr", ram_if.ram_addr, a);
    chk("hw_data", ram_if.ram_wdata, d);
    ref_mem[a] = d;
    @(negedge clk);
    ext_we = 0;
  endtask

  task automatic do_dump(input logic [AW-1:0] base, input int len);
    int n0;
    bit fin;
    logic [AW-1:0] a;
    @(negedge clk);
    dump_start = 1; dump_base = base; dump_len = len[AW:0];
    n0 = n_start;
    txq.delete();
    @(negedge clk);
    dump_start = 0;
    m_dd = (len == 0);
    chk("dd_start", dump_done, m_dd);
    chk("dd_state0", state, len == 0 ? S_HOST : S_DUMP_RD);
    fin = (len == 0);
    for (int k = 0; k < len * 20 + 20 && !fin; k++) begin
      @(negedge clk);
      if (dump_done) begin
        fin = 1;
        ext_we = 0; rx_valid = 0; dump_start = 0;
      end else begin
        ext_we = 1'($urandom);
        ext_addr = AW'($urandom);
        ext_wdata = DW'($urandom);
        rx_valid = (k == 5);
        if (k == 5) m_ovr = 1;
        dump_start = (k == 7);
        dump_base = base + 4'd7;
        #1 chk("dump_we", ram_if.ram_we, 0);
      end
    end
    if (!fin) chk("dump_timeout", 0, 1);
    m_dd = 1;
    repeat (3) @(negedge clk);
    chk("dd_done", dump_done, 1);
    chk("dd_host", state, S_HOST);
    chk("dd_ovr", overrun, m_ovr);
    chk("dd_count", n_start - n0, len);
    for (int i = 0; i < len; i++) begin
      a = base + AW'(i);
      if (i < txq.size()) chk("dd_byte", txq[i], ref_mem[a]);
      else chk("dd_missing", 0, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    bit seen;
    for (int i = 0; i < 16; i++) begin
      ram[i] = 0;
      ref_mem[i] = 0;
    end
    model_clear();
    rx_valid = 1; rx_byte = 8'h5A;
    #12;
    chk("rst_we", ram_if.ram_we, 0);
    chk("rst_addr", ram_if.ram_addr, 0);
    chk("rst_wdata", ram_if.ram_wdata, 0);
    chk("rst_txs", tx_start, 0);
    chk("rst_txb", tx_byte, 0);
    chk("rst_flags", {load_done, dump_done, overrun}, 0);
    chk("rst_state", state, S_LOAD);
    @(posedge clk);
    #2 rst_n = 1; rx_valid = 0;

    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("ld_ovr", overrun, 0);

    do_dump(4'h1, 2);
    host_wr(4'h2, 8'hA5);

    @(negedge clk);
    rx_valid = 1; rx_byte = 8'hEE;
    #1 chk("host_rx_we", ram_if.ram_we, 0);
    @(negedge clk);
    rx_valid = 0;
    m_ovr = 1;
    chk("host_ovr", overrun, 1);

    host_wr(4'hF, DW'($urandom));
    do_dump(4'hF, 2);
    do_dump(4'h3, 0);

    for (int r = 0; r < 3; r++) begin
      host_wr(AW'($urandom), DW'($urandom));
      host_wr(AW'($urandom), DW'($urandom));
      do_dump(AW'($urandom), 1 + $urandom % 4);
    end

    // abort a 3-byte dump while waiting on the transmitter
    @(negedge clk);
    dump_start = 1; dump_base = 0; dump_len = 3;
    n0 = n_start;
    @(negedge clk);
    dump_start = 0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = (n_start == n0 + 1);
    end
    if (!seen) chk("abort_timeout", 0, 1);
    repeat (3) @(negedge clk);
    chk("abort_pre", state, S_DUMP_WAIT);
    load_restart = 1;
    @(negedge clk);
    load_restart = 0;
    model_clear();
    chk("abort_state", state, S_LOAD);
    chk("abort_flags", {load_done, dump_done, overrun}, 0);
    repeat (40) @(negedge clk);
    chk("abort_notx", n_start - n0, 1);
    chk("abort_stay", state, S_LOAD);

    for (int i = 0; i < 4; i++) send(DW'($urandom));

    // restart beats a simultaneous dump request
    @(negedge clk);
    load_restart = 1; dump_start = 1; dump_len = 2;
    n0 = n_start;
    @(negedge clk);
    load_restart = 0; dump_start = 0;
    model_clear();
    chk("race_state", state, S_LOAD);
    chk("race_ld", load_done, 0);
    repeat (20) @(negedge clk);
    chk("race_notx", n_start - n0, 0);

    // async reset mid-load
    send(DW'($urandom)); send(DW'($urandom));
    @(negedge clk);
    #2 rst_n = 0; rx_valid = 1; rx_byte = 8'hFF;
    #1;
    chk("arst_we", ram_if.ram_we, 0);
    chk("arst_wdata", ram_if.ram_wdata, 0);
    chk("arst_addr", ram_if.ram_addr, 0);
    chk("arst_txb", tx_byte, 0);
    chk("arst_state", state, S_LOAD);
    @(posedge clk);
    #2 rst_n = 1; rx_valid = 0;
    model_clear();
    for (int i = 0; i < 4; i++) send(DW'($urandom));
    do_dump(4'h0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
